// File: rtl/saradc_11b_dig_dither_pkg.sv
// Shared types, constants and helpers for the SAR ADC dither controller.
package saradc_11b_dig_dither_pkg;

  localparam int                LFSR_W    = 10;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 10'h3FF;
  localparam int                TAP_HI    = 9;
  localparam int                TAP_LO    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    VALID = 2'd2
  } dither_state_t;

  // One Fibonacci step of x^10 + x^7 + 1: shift up, feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

  // The all-zero state is the LFSR lock-up state, so a zero seed becomes all-ones.
  function automatic logic [LFSR_W-1:0] sanitize_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_INIT : s;
  endfunction

endpackage

// File: rtl/saradc_11b_dig_dither_lfsr.sv
// 10-bit maximal-length LFSR with step, load and lock-up recovery.
// Lock-up recovery has priority over load and step so a corrupted state
// never survives more than one cycle.
module saradc_11b_dig_dither_lfsr
  import saradc_11b_dig_dither_pkg::*;
#(
  parameter int DITHER_W = 4
) (
  input  logic                clk,
  input  logic                res,
  input  logic                step_i,
  input  logic                load_i,
  input  logic [LFSR_W-1:0]   load_val_i,
  output logic [LFSR_W-1:0]   state_o,
  output logic [DITHER_W-1:0] code_next_o,
  output logic                zero_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next-state selection: recovery, then load, then step, else hold.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (state_q == '0) begin
      state_d = LFSR_INIT;
    end else if (load_i) begin
      state_d = load_val_i;
    end else if (step_i) begin
      state_d = lfsr_advance(state_q);
    end
  end

  // State register with synchronous reset to the all-ones seed.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= LFSR_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o     = state_q;
  assign code_next_o = state_d[DITHER_W-1:0];
  assign zero_o      = (state_q == '0);

endmodule

// File: rtl/saradc_11b_dig_dither_ctrl.sv
// Dither controller: on request, advances the LFSR a programmed number of
// steps and offers the low DITHER_W bits on a valid/ack handshake.
module saradc_11b_dig_dither_ctrl
  import saradc_11b_dig_dither_pkg::*;
#(
  parameter int DITHER_W = 4,
  parameter int STEPS_W  = 4
) (
  input  logic                clk,
  input  logic                res,
  input  logic                enable_i,
  input  logic [STEPS_W-1:0]  cfg_steps_i,
  input  logic                seed_load_i,
  input  logic [LFSR_W-1:0]   seed_i,
  input  logic                dither_req_i,
  output logic                dither_vld_o,
  input  logic                dither_ack_i,
  output logic [DITHER_W-1:0] dither_o,
  output logic                busy_o,
  output logic                lockup_err_o,
  output logic [LFSR_W-1:0]   lfsr_state_o
);

  dither_state_t       state_q, state_d;
  logic [STEPS_W-1:0]  cnt_q, cnt_d;
  logic [DITHER_W-1:0] dither_q, dither_d;
  logic                lockup_q, lockup_d;

  logic                lfsr_step;
  logic                lfsr_load;
  logic [DITHER_W-1:0] lfsr_code_next;
  logic                lfsr_zero;

  saradc_11b_dig_dither_lfsr #(
    .DITHER_W (DITHER_W)
  ) u_lfsr (
    .clk         (clk),
    .res         (res),
    .step_i      (lfsr_step),
    .load_i      (lfsr_load),
    .load_val_i  (sanitize_seed(seed_i)),
    .state_o     (lfsr_state_o),
    .code_next_o (lfsr_code_next),
    .zero_o      (lfsr_zero)
  );

  // Next-state and datapath control. Settings are only looked at in IDLE,
  // so a request in flight finishes with what was captured at accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dither_d  = dither_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    lockup_d  = lockup_q | lfsr_zero;

    unique case (state_q)
      IDLE: begin
        dither_d = '0;
        if (seed_load_i) begin
          lfsr_load = 1'b1;
        end else if (dither_req_i) begin
          if (enable_i) begin
            cnt_d   = (cfg_steps_i == '0) ? STEPS_W'(1) : cfg_steps_i;
            state_d = STEP;
          end else begin
            state_d = VALID;
          end
        end
      end

      STEP: begin
        lfsr_step = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q <= STEPS_W'(1)) begin
          state_d  = VALID;
          // Capture the code the LFSR will hold after this final step.
          dither_d = lfsr_code_next;
        end
      end

      VALID: begin
        if (dither_ack_i) begin
          state_d  = IDLE;
          dither_d = '0;
        end
      end

      default: begin
        state_d  = IDLE;
        dither_d = '0;
      end
    endcase
  end

  // Controller registers; reset wins over any transaction in progress.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dither_q <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dither_q <= dither_d;
      lockup_q <= lockup_d;
    end
  end

  assign dither_vld_o = (state_q == VALID);
  assign busy_o       = (state_q != IDLE);
  assign dither_o     = dither_q;
  assign lockup_err_o = lockup_q;

endmodule

// File: tb/tb_saradc_11b_dig_dither_ctrl.sv
// Self-checking bench for saradc_11b_dig_dither_ctrl. The reference model is
// the precomputed m-sequence plus a position index into it.
module tb_saradc_11b_dig_dither_ctrl;

  logic       clk;
  logic       res;
  logic       enable_i;
  logic [3:0] cfg_steps_i;
  logic       seed_load_i;
  logic [9:0] seed_i;
  logic       dither_req_i;
  logic       dither_vld_o;
  logic       dither_ack_i;
  logic [3:0] dither_o;
  logic       busy_o;
  logic       lockup_err_o;
  logic [9:0] lfsr_state_o;

  saradc_11b_dig_dither_ctrl #(
    .DITHER_W (4),
    .STEPS_W  (4)
  ) dut (
    .clk          (clk),
    .res          (res),
    .enable_i     (enable_i),
    .cfg_steps_i  (cfg_steps_i),
    .seed_load_i  (seed_load_i),
    .seed_i       (seed_i),
    .dither_req_i (dither_req_i),
    .dither_vld_o (dither_vld_o),
    .dither_ack_i (dither_ack_i),
    .dither_o     (dither_o),
    .busy_o       (busy_o),
    .lockup_err_o (lockup_err_o),
    .lfsr_state_o (lfsr_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] seq [1023];
  int         pos;
  bit         visited [1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Build the m-sequence starting at 3FF with plain integer arithmetic.
  task automatic build_seq();
    int s;
    s = 1023;
    for (int i = 0; i < 1023; i++) begin
      seq[i] = s[9:0];
      s = ((s * 2) % 1024) + (((s / 512) + (s / 64)) % 2);
    end
  endtask

  function automatic int find_pos(input logic [9:0] v);
    int p;
    p = 0;
    for (int i = 0; i < 1023; i++) if (seq[i] == v) p = i;
    return p;
  endfunction

  task automatic do_reset();
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    pos = 0;
  endtask

  task automatic load_seed(input logic [9:0] v);
    seed_i      = v;
    seed_load_i = 1'b1;
    @(posedge clk); #1;
    seed_load_i = 1'b0;
    pos = find_pos((v == 10'h000) ? 10'h3FF : v);
    check("seed_state", lfsr_state_o, seq[pos]);
    check("seed_busy", busy_o, 1'b0);
  endtask

  // One full request/handshake. After the accept edge the settings are
  // scrambled (and optionally a seed load is attempted) to prove they are ignored.
  task automatic do_req(input int steps, input bit en, input int ack_dly, input bit poke);
    int  n_eff, lat, exp_lat;
    bit  seen;
    logic [3:0] exp_d;
    n_eff        = (steps == 0) ? 1 : steps;
    cfg_steps_i  = steps[3:0];
    enable_i     = en;
    dither_req_i = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      lat++;
      if (c == 0) begin
        dither_req_i = 1'b0;
        cfg_steps_i  = 4'($urandom);
        enable_i     = 1'($urandom);
        seed_load_i  = poke;
        seed_i       = 10'($urandom_range(1, 1023));
      end
      if (dither_vld_o) seen = 1'b1;
    end
    seed_load_i = 1'b0;
    if (en) begin
      pos     = (pos + n_eff) % 1023;
      exp_lat = n_eff + 1;
      exp_d   = seq[pos][3:0];
    end else begin
      exp_lat = 1;
      exp_d   = 4'h0;
    end
    check("req_latency", lat, exp_lat);
    check("req_dither", dither_o, exp_d);
    check("req_state", lfsr_state_o, seq[pos]);
    check("req_busy", busy_o, 1'b1);
    for (int d = 0; d < ack_dly; d++) begin
      @(posedge clk); #1;
      check("hold_vld", dither_vld_o, 1'b1);
      check("hold_dither", dither_o, exp_d);
    end
    dither_ack_i = 1'b1;
    @(posedge clk); #1;
    dither_ack_i = 1'b0;
    check("ack_vld", dither_vld_o, 1'b0);
    check("ack_dither", dither_o, 4'h0);
    check("ack_busy", busy_o, 1'b0);
  endtask

  initial begin
    int revisits;
    res          = 1'b0;
    enable_i     = 1'b1;
    cfg_steps_i  = '0;
    seed_load_i  = 1'b0;
    seed_i       = '0;
    dither_req_i = 1'b0;
    dither_ack_i = 1'b0;
    build_seq();

    // Reset values.
    do_reset();
    check("rst_vld", dither_vld_o, 1'b0);
    check("rst_dither", dither_o, 4'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_lockup", lockup_err_o, 1'b0);
    check("rst_state", lfsr_state_o, 10'h3FF);

    // Single step from reset: 3FE / E; ack ignored while idle.
    dither_ack_i = 1'b1;
    @(posedge clk); #1;
    dither_ack_i = 1'b0;
    check("idle_ack_vld", dither_vld_o, 1'b0);
    do_req(1, 1'b1, 0, 1'b0);
    check("t1_state", lfsr_state_o, 10'h3FE);

    // Three steps from reset: 3F8 / 8.
    do_reset();
    do_req(3, 1'b1, 2, 1'b0);
    check("t2_state", lfsr_state_o, 10'h3F8);

    // Zero steps behave as one.
    do_req(0, 1'b1, 0, 1'b0);

    // Full period with single-step requests.
    do_reset();
    foreach (visited[i]) visited[i] = 1'b0;
    visited[10'h3FF] = 1'b1;
    revisits = 0;
    for (int i = 0; i < 1023; i++) begin
      do_req(1, 1'b1, 0, 1'b0);
      if (i < 1022) begin
        if (visited[lfsr_state_o]) revisits++;
        visited[lfsr_state_o] = 1'b1;
      end
    end
    check("period_revisits", revisits, 0);
    check("period_state", lfsr_state_o, 10'h3FF);
    check("period_lockup", lockup_err_o, 1'b0);

    // Seed handling: zero seed, seed+req collision, seed during STEP.
    do_reset();
    do_req(5, 1'b1, 0, 1'b0);
    load_seed(10'h000);
    seed_i       = 10'h155;
    seed_load_i  = 1'b1;
    cfg_steps_i  = 4'd1;
    enable_i     = 1'b1;
    dither_req_i = 1'b1;
    @(posedge clk); #1;
    seed_load_i = 1'b0;
    pos = find_pos(10'h155);
    check("collide_state", lfsr_state_o, 10'h155);
    check("collide_busy", busy_o, 1'b0);
    do_req(1, 1'b1, 0, 1'b0);
    do_req(9, 1'b1, 1, 1'b1);

    // Bypass: code 0, LFSR frozen, stable while ack held low.
    do_req(7, 1'b0, 5, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0)
        load_seed(($urandom_range(0, 7) == 0) ? 10'h000 : 10'($urandom));
      do_req(int'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Lock-up: hold the LFSR at zero across one edge.
    do_reset();
    @(negedge clk);
    force dut.u_lfsr.state_q = 10'h000;
    @(posedge clk); #1;
    release dut.u_lfsr.state_q;
    check("lockup_set", lockup_err_o, 1'b1);
    @(posedge clk); #1;
    check("lockup_recover", lfsr_state_o, 10'h3FF);
    pos = 0;
    do_req(2, 1'b1, 0, 1'b0);
    check("lockup_sticky", lockup_err_o, 1'b1);

    // Reset in the middle of a long STEP phase.
    cfg_steps_i  = 4'd15;
    enable_i     = 1'b1;
    dither_req_i = 1'b1;
    @(posedge clk); #1;
    dither_req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", busy_o, 1'b1);
    res = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_vld", dither_vld_o, 1'b0);
    check("mid_rst_dither", dither_o, 4'h0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_lockup", lockup_err_o, 1'b0);
    check("mid_rst_state", lfsr_state_o, 10'h3FF);
    res = 1'b0;
    pos = 0;
    do_req(4, 1'b1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
